// File: rtl/regfile_mp.sv
// regfile_mp: multi-port LEGv8 register file with two write ports, a pending-bit scoreboard
// and hardwired zero register ZR. Define REGFILE_BYPASS_EN for same-cycle write-through.
module regfile_mp #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned NR    = 2,
  parameter int unsigned ZR    = DEPTH - 1,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [WIDTH-1:0]    wd1,
  input  logic                we2,
  input  logic [AW-1:0]       wa2,
  input  logic [WIDTH-1:0]    wd2,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  input  logic [NR*AW-1:0]    ra,
  output logic [NR*WIDTH-1:0] rd,
  output logic [NR-1:0]       busy
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] pending_q, pending_d;
  logic             wv1, wv2, rv;

  // Address refers to a real, writable register (not ZR, not beyond DEPTH).
  function automatic logic addr_ok(logic [AW-1:0] a);
    return (32'(a) < DEPTH) && (32'(a) != ZR);
  endfunction

  assign wv1 = (we1 === 1'b1) && addr_ok(wa1);
  assign wv2 = (we2 === 1'b1) && addr_ok(wa2);
  assign rv  = (rsv_en === 1'b1) && addr_ok(rsv_addr);

  always_comb begin
    for (int unsigned r = 0; r < DEPTH; r++) begin
      regs_d[r]    = regs_q[r];
      pending_d[r] = pending_q[r];
      if (r != ZR) begin
        if (wv1 && wa1 == AW'(r)) regs_d[r] = wd1;
        if (wv2 && wa2 == AW'(r)) regs_d[r] = wd2;
        if ((wv1 && wa1 == AW'(r)) || (wv2 && wa2 == AW'(r))) pending_d[r] = 1'b0;
        // A new reservation supersedes a completing older producer.
        if (rv && rsv_addr == AW'(r)) pending_d[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        regs_q[r] <= (r == ZR) ? '0 : WIDTH'(r);
      end
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    logic [AW-1:0] a;
    a    = '0;
    rd   = '0;
    busy = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      a = ra[k*AW +: AW];
      if (addr_ok(a)) begin
        rd[k*WIDTH +: WIDTH] = regs_q[a];
        busy[k]              = pending_q[a];
`ifdef REGFILE_BYPASS_EN
        if (wv2 && wa2 == a) begin
          rd[k*WIDTH +: WIDTH] = wd2;
        end else if (wv1 && wa1 == a) begin
          rd[k*WIDTH +: WIDTH] = wd1;
        end
        if ((wv1 && wa1 == a) || (wv2 && wa2 == a)) begin
          busy[k] = rv && (rsv_addr == a);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random traffic, scored against
// a behavioural register-file model through an expectation queue.
module tb_regfile_mp;
  localparam int unsigned WIDTH = 64;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned NR    = 2;
  localparam int unsigned ZR    = DEPTH - 1;
  localparam int unsigned AW    = 5;

  logic                clk = 1'b0;
  logic                reset, we1, we2, rsv_en;
  logic [AW-1:0]       wa1, wa2, rsv_addr;
  logic [WIDTH-1:0]    wd1, wd2;
  logic [NR*AW-1:0]    ra;
  logic [NR*WIDTH-1:0] rd;
  logic [NR-1:0]       busy;

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NR(NR), .ZR(ZR)) dut (
    .clk(clk), .reset(reset),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .we2(we2), .wa2(wa2), .wd2(wd2),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .ra(ra), .rd(rd), .busy(busy)
  );

  typedef struct {
    logic [NR*WIDTH-1:0] rd;
    logic [NR-1:0]       busy;
    int                  id;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] m_reg [DEPTH];
  bit               m_pend [DEPTH];
  bit               m_ok = 1'b0;
  int               n_checks = 0;
  int               n_fail = 0;
  int               n_items = 0;

  function automatic bit real_reg(int unsigned a);
    return (a < DEPTH) && (a != ZR);
  endfunction

  function automatic logic [WIDTH-1:0] exp_rd(int unsigned a);
    if (!real_reg(a)) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we2 && real_reg(wa2) && wa2 == a) return wd2;
    if (we1 && real_reg(wa1) && wa1 == a) return wd1;
`endif
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(int unsigned a);
    if (!real_reg(a)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if ((we1 && real_reg(wa1) && wa1 == a) || (we2 && real_reg(wa2) && wa2 == a))
      return rsv_en && real_reg(rsv_addr) && rsv_addr == a;
`endif
    return m_pend[a];
  endfunction

  task automatic idle();
    reset = 1'b0; we1 = 1'b0; we2 = 1'b0; rsv_en = 1'b0;
    wa1 = '0; wa2 = '0; wd1 = '0; wd2 = '0; rsv_addr = '0;
  endtask

  // Push the expected combinational outputs, then advance one clock and update the model.
  task automatic cycle();
    exp_t e;
    if (m_ok) begin
      for (int k = 0; k < NR; k++) begin
        e.rd[k*WIDTH +: WIDTH] = exp_rd(int'(ra[k*AW +: AW]));
        e.busy[k]              = exp_busy(int'(ra[k*AW +: AW]));
      end
      e.id = n_items++;
      sb.push_back(e);
    end
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_reg[i]  = (i == ZR) ? '0 : WIDTH'(i);
        m_pend[i] = 1'b0;
      end
      m_ok = 1'b1;
    end else begin
      if (we1 && real_reg(wa1)) m_reg[wa1] = wd1;
      if (we2 && real_reg(wa2)) m_reg[wa2] = wd2;
      if (we1 && real_reg(wa1)) m_pend[wa1] = 1'b0;
      if (we2 && real_reg(wa2)) m_pend[wa2] = 1'b0;
      if (rsv_en && real_reg(rsv_addr)) m_pend[rsv_addr] = 1'b1;
    end
    #1;
  endtask

  function automatic logic [AW-1:0] rnd_addr(bit narrow);
    if (!narrow) return AW'($urandom_range(0, DEPTH - 1));
    if ($urandom_range(0, 9) == 0) return AW'(ZR);
    return AW'($urandom_range(0, 7));
  endfunction

  // Monitor: outputs are combinational, so sample mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (rd !== e.rd) begin
        n_fail++;
        $display("FAIL rd item %0d: got %h expected %h", e.id, rd, e.rd);
      end
      n_checks++;
      if (busy !== e.busy) begin
        n_fail++;
        $display("FAIL busy item %0d: got %b expected %b", e.id, busy, e.busy);
      end
    end
  end

  initial begin
    bit narrow;
    idle();
    ra = '0;
    @(posedge clk);
    #1;

    // 1: reset, then read 5 and ZR
    reset = 1'b1; cycle(); idle();
    ra = {5'd31, 5'd5}; cycle();
    // 2: write 3 then read it
    we1 = 1'b1; wa1 = 5'd3; wd1 = 64'hDEAD; ra = {5'd31, 5'd3}; cycle(); idle();
    cycle();
    // 3: both ports to 7, then ZR write ignored
    we1 = 1'b1; we2 = 1'b1; wa1 = 5'd7; wa2 = 5'd7; wd1 = 64'd1; wd2 = 64'd2;
    ra = {5'd3, 5'd7}; cycle(); idle();
    cycle();
    we1 = 1'b1; wa1 = 5'd31; wd1 = 64'd9; ra = {5'd7, 5'd31}; cycle(); idle();
    cycle();
    // 4: reserve 9, then load return clears it
    rsv_en = 1'b1; rsv_addr = 5'd9; ra = {5'd31, 5'd9}; cycle(); idle();
    cycle();
    we2 = 1'b1; wa2 = 5'd9; wd2 = 64'd77; cycle(); idle();
    cycle();
    // 5: reserve and write to 4 together; reserve of ZR ignored
    rsv_en = 1'b1; rsv_addr = 5'd4; we1 = 1'b1; wa1 = 5'd4; wd1 = 64'h44; ra = {5'd31, 5'd4};
    cycle(); idle();
    cycle();
    rsv_en = 1'b1; rsv_addr = 5'd31; ra = {5'd4, 5'd31}; cycle(); idle();
    cycle();
    // 6: reset wins over a same-cycle write
    rsv_en = 1'b1; rsv_addr = 5'd10; we2 = 1'b1; wa2 = 5'd11; wd2 = 64'h1111;
    ra = {5'd10, 5'd11}; cycle(); idle();
    reset = 1'b1; we1 = 1'b1; wa1 = 5'd2; wd1 = 64'd5; ra = {5'd10, 5'd2}; cycle(); idle();
    cycle();
    ra = {5'd4, 5'd9}; cycle();

    // Random traffic, alternating between dense and sparse address windows.
    for (int n = 0; n < 3000; n++) begin
      narrow   = ((n / 200) % 2) == 0;
      reset    = ($urandom_range(0, 149) == 0);
      we1      = $urandom_range(0, 1);
      we2      = $urandom_range(0, 2) == 0;
      rsv_en   = $urandom_range(0, 2) != 0;
      wa1      = rnd_addr(narrow);
      wa2      = rnd_addr(narrow);
      rsv_addr = rnd_addr(narrow);
      wd1      = {$urandom, $urandom};
      wd2      = {$urandom, $urandom};
      for (int k = 0; k < NR; k++) ra[k*AW +: AW] = rnd_addr(narrow);
      cycle();
    end
    idle();

    for (int t = 0; t < 20 && sb.size() > 0; t++) @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
